bp_cfg_sequencer: RTL and testbench
===================================

// Module: bp_cfg_sequencer
// PURPOSE
//  - Boot-time configuration controller for a BlackParrot multicore.
//  - Walks every core tile over the shared config bus and writes the per-core registers:
//    freeze, core_id, cce_id, cce_mode and boot npc.
//  - Then releases freeze on each core in turn.
//  - Sits between the host/reset logic and the cfg-bus fanout.
//  - Core count comes from the selected processor config (cc_x_dim*cc_y_dim).
// PARAMETERS
//  num_core_p        4             cores to configure; >=1, <=256
//  core_id_width_p   8             width of cfg_core_o and of core_id/cce_id data
//  cfg_addr_width_p  16            cfg register address width
//  cfg_data_width_p  64            cfg data width
//  boot_pc_p         'h8000_0000   value written to npc register
//  cce_mode_p        0             value written to cce_mode (0=normal,1=uncached)
// PORTS
//  clk_i         in   1                 clock
//  reset_n_i     in   1                 one clock; reset asynchronous, active-low
//  start_i       in   1                 pulse: begin sequence (ignored while busy_o)
//  cfg_v_o       out  1                 cfg transaction valid
//  cfg_ready_i   in   1                 cfg bus accepts when cfg_v_o&cfg_ready_i
//  cfg_w_o       out  1                 1=write, 0=read
//  cfg_core_o    out  core_id_width_p   target core
//  cfg_addr_o    out  cfg_addr_width_p  register address
//  cfg_data_o    out  cfg_data_width_p  write data
//  rdata_v_i     in   1                 readback data valid (readback build only)
//  rdata_i       in   cfg_data_width_p  readback data
//  busy_o        out  1                 sequence in progress
//  done_o        out  1                 sequence complete; held until next start_i
//  error_o       out  1                 sticky readback mismatch
// BEHAVIOUR
//  - Reset (async, reset_n_i=0): state=IDLE; all outputs 0; counters 0.
//    Mid-sequence reset aborts immediately, with no further cfg traffic.
//  - States: IDLE -> CFG -> (RD -> WAIT) -> next CFG | UNFRZ -> DONE.
//  - IDLE: start_i=1 -> CFG with core=0, reg=0. Set busy_o=1; clear done_o and error_o.
//  - CFG: cfg_v_o=1 the cycle after start_i, cfg_w_o=1.
//    - reg index 0..4 = freeze(data 1), core_id(core), cce_id(core), cce_mode(cce_mode_p), npc(boot_pc_p).
//    - Hold all cfg_* stable until cfg_ready_i. One transaction per handshake; no bubbles required.
//    - On handshake, reg++. After reg 4: reg=0, core++.
//    - After core num_core_p-1, reg 4: core=0 -> UNFRZ.
//  - UNFRZ: write freeze=0 to core 0..num_core_p-1, one per handshake. After last -> DONE.
//  - DONE: cfg_v_o=0, busy_o=0, done_o=1. start_i restarts from IDLE semantics.
//  - Total writes = 6*num_core_p. Core counter wraps exactly at num_core_p (non-power-of-2 legal).
//  - Data zero-extended to cfg_data_width_p; core index zero-extended to core_id_width_p.
//  - start_i while busy_o: ignored. cfg_ready_i while cfg_v_o=0: ignored.
// CONFIGURATION
//  - BP_CFG_SEQ_READBACK_EN defined:
//    - After every accepted write, enter RD: one read (cfg_w_o=0) of the same core/addr.
//    - After its handshake, WAIT until rdata_v_i.
//    - Compare rdata_i to the written data; a mismatch sets error_o (sticky) and the sequence continues.
//    - rdata_v_i outside WAIT is ignored.
//  - Undefined: RD/WAIT states are absent; error_o tied 0; rdata_v_i/rdata_i unused.
// STRUCTURE
//  - Shared package bp_cfg_seq_pkg:
//    - enum bp_cfg_seq_state_e.
//    - Register address localparams: freeze/core_id/cce_id/cce_mode/npc.
//    - Register count localparam = 5.
//  - Sub-module bp_cfg_seq_rom: combinational reg index -> {addr, data} table.
//  - FSM and counters live in bp_cfg_sequencer.
// TESTING
//  - num_core_p=2, cfg_ready_i=1, start_i pulse:
//    - 12 writes in 12 consecutive cycles, in order c0:freeze=1,id=0,cce=0,mode=0,npc=0x8000_0000;
//      then c1 likewise; then c0 freeze=0, c1 freeze=0.
//    - done_o=1 on the next cycle.
//  - Random cfg_ready_i backpressure (30% high): identical transaction order;
//    cfg_* stable while cfg_v_o&!cfg_ready_i.
//  - num_core_p=3: core wraps 2->0 into UNFRZ; 18 writes total; no write targets core 3.
//  - reset_n_i low during core 1 reg 2: all outputs 0 asynchronously.
//    After release and start_i, the sequence restarts at c0 reg 0.
//  - start_i pulsed at write 5: ignored, 12 writes total. start_i in DONE: full repeat, done_o drops.
//  - READBACK_EN, rdata_i corrupted on c0 npc read: error_o=1 and remains set.
//    Sequence completes with 24 transactions; done_o=1.

Source files
------------

// File: rtl/bp_cfg_seq_pkg.sv
// Shared types and register map for the BlackParrot boot-time config sequencer.
// The readback variant is selected with the BP_CFG_SEQ_READBACK_EN macro.
package bp_cfg_seq_pkg;

    typedef enum logic [2:0] {
        e_idle,
        e_cfg,
        e_rd,
        e_wait,
        e_unfrz,
        e_done
    } bp_cfg_seq_state_e;

    // Per-core register walk order; index doubles as the counter value.
    typedef enum logic [2:0] {
        e_reg_freeze,
        e_reg_core_id,
        e_reg_cce_id,
        e_reg_cce_mode,
        e_reg_npc
    } bp_cfg_reg_e;

    localparam int unsigned cfg_reg_count_lp   = 5;
    localparam int unsigned reg_idx_width_lp   = 3;

    localparam logic [15:0] cfg_addr_freeze_lp   = 16'h0002;
    localparam logic [15:0] cfg_addr_core_id_lp  = 16'h0004;
    localparam logic [15:0] cfg_addr_cce_id_lp   = 16'h0005;
    localparam logic [15:0] cfg_addr_cce_mode_lp = 16'h0006;
    localparam logic [15:0] cfg_addr_npc_lp      = 16'h0007;

endpackage

// File: rtl/bp_cfg_seq_rom.sv
// Combinational lookup: register index (plus target core) -> cfg address and write data.
// Unfreeze writes reuse the freeze entry with the data bit inverted.
module bp_cfg_seq_rom
    import bp_cfg_seq_pkg::*;
#(
    parameter int          core_id_width_p  = 8,
    parameter int          cfg_addr_width_p = 16,
    parameter int          cfg_data_width_p = 64,
    parameter logic [63:0] boot_pc_p        = 64'h8000_0000,
    parameter int unsigned cce_mode_p       = 0
) (
    input  logic [reg_idx_width_lp-1:0]  reg_idx,
    input  logic [core_id_width_p-1:0]   core,
    input  logic                         unfreeze,
    output logic [cfg_addr_width_p-1:0]  addr,
    output logic [cfg_data_width_p-1:0]  data
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        addr = cfg_addr_width_p'(cfg_addr_freeze_lp);
        data = '0;
        case (reg_idx)
            e_reg_freeze: begin
                addr    = cfg_addr_width_p'(cfg_addr_freeze_lp);
                data[0] = ~unfreeze;
            end
            e_reg_core_id: begin
                addr = cfg_addr_width_p'(cfg_addr_core_id_lp);
                data = cfg_data_width_p'(core);
            end
            e_reg_cce_id: begin
                addr = cfg_addr_width_p'(cfg_addr_cce_id_lp);
                data = cfg_data_width_p'(core);
            end
            e_reg_cce_mode: begin
                addr = cfg_addr_width_p'(cfg_addr_cce_mode_lp);
                data = cfg_data_width_p'(cce_mode_p);
            end
            e_reg_npc: begin
                addr = cfg_addr_width_p'(cfg_addr_npc_lp);
                data = cfg_data_width_p'(boot_pc_p);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bp_cfg_sequencer.sv
// Boot-time config walker: writes freeze/ids/mode/npc to every core, then unfreezes each.
// Define BP_CFG_SEQ_READBACK_EN to read back and verify every write.
module bp_cfg_sequencer
    import bp_cfg_seq_pkg::*;
#(
    parameter int          num_core_p       = 4,
    parameter int          core_id_width_p  = 8,
    parameter int          cfg_addr_width_p = 16,
    parameter int          cfg_data_width_p = 64,
    parameter logic [63:0] boot_pc_p        = 64'h8000_0000,
    parameter int unsigned cce_mode_p       = 0
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         start_i,
    output logic                         cfg_v_o,
    input  logic                         cfg_ready_i,
    output logic                         cfg_w_o,
    output logic [core_id_width_p-1:0]   cfg_core_o,
    output logic [cfg_addr_width_p-1:0]  cfg_addr_o,
    output logic [cfg_data_width_p-1:0]  cfg_data_o,
    input  logic                         rdata_v_i,
    input  logic [cfg_data_width_p-1:0]  rdata_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         error_o
);

    localparam int core_cnt_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;
    localparam logic [core_cnt_width_lp-1:0] last_core_lp = core_cnt_width_lp'(num_core_p - 1);
    localparam logic [reg_idx_width_lp-1:0]  last_reg_lp  = reg_idx_width_lp'(cfg_reg_count_lp - 1);

    bp_cfg_seq_state_e              state_q;
    logic [core_cnt_width_lp-1:0]   core_q, nxt_core;
    logic [reg_idx_width_lp-1:0]    reg_q, nxt_reg;
    logic                           unfrz_q, nxt_unfrz, nxt_done;
    logic                           advance;
    logic [core_id_width_p-1:0]     nxt_core_id;
    logic [cfg_addr_width_p-1:0]    rom_addr;
    logic [cfg_data_width_p-1:0]    rom_data;

    // Index of the transaction to issue when the sequence advances.
    always_comb begin
        nxt_core  = core_q;
        nxt_reg   = reg_q;
        nxt_unfrz = unfrz_q;
        nxt_done  = 1'b0;
        if (state_q == e_idle || state_q == e_done) begin
            nxt_core  = '0;
            nxt_reg   = '0;
            nxt_unfrz = 1'b0;
        end else if (unfrz_q) begin
            if (core_q == last_core_lp) nxt_done = 1'b1;
            else                        nxt_core = core_q + 1'b1;
        end else if (reg_q == last_reg_lp) begin
            nxt_reg = '0;
            if (core_q == last_core_lp) begin
                nxt_core  = '0;
                nxt_unfrz = 1'b1;
            end else begin
                nxt_core = core_q + 1'b1;
            end
        end else begin
            nxt_reg = reg_q + 1'b1;
        end
    end

    always_comb begin
        advance = 1'b0;
        case (state_q)
            e_idle, e_done: advance = start_i;
`ifdef BP_CFG_SEQ_READBACK_EN
            e_wait:         advance = rdata_v_i;
`else
            e_cfg, e_unfrz: advance = cfg_v_o & cfg_ready_i;
`endif
            default:        advance = 1'b0;
        endcase
    end

    assign nxt_core_id = core_id_width_p'(nxt_core);

    bp_cfg_seq_rom #(
        .core_id_width_p  (core_id_width_p),
        .cfg_addr_width_p (cfg_addr_width_p),
        .cfg_data_width_p (cfg_data_width_p),
        .boot_pc_p        (boot_pc_p),
        .cce_mode_p       (cce_mode_p)
    ) u_rom (
        .reg_idx  (nxt_reg),
        .core     (nxt_core_id),
        .unfreeze (nxt_unfrz),
        .addr     (rom_addr),
        .data     (rom_data)
    );

`ifdef BP_CFG_SEQ_READBACK_EN
    logic error_q;
    assign error_o = error_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^{rdata_v_i, rdata_i};
    assign error_o      = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= e_idle;
            core_q     <= '0;
            reg_q      <= '0;
            unfrz_q    <= 1'b0;
            cfg_v_o    <= 1'b0;
            cfg_w_o    <= 1'b0;
            cfg_core_o <= '0;
            cfg_addr_o <= '0;
            cfg_data_o <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
`ifdef BP_CFG_SEQ_READBACK_EN
            error_q    <= 1'b0;
`endif
        end else if (advance) begin
            core_q  <= nxt_core;
            reg_q   <= nxt_reg;
            unfrz_q <= nxt_unfrz;
            if (nxt_done) begin
                state_q <= e_done;
                cfg_v_o <= 1'b0;
                cfg_w_o <= 1'b0;
                busy_o  <= 1'b0;
                done_o  <= 1'b1;
            end else begin
                state_q    <= nxt_unfrz ? e_unfrz : e_cfg;
                cfg_v_o    <= 1'b1;
                cfg_w_o    <= 1'b1;
                cfg_core_o <= nxt_core_id;
                cfg_addr_o <= rom_addr;
                cfg_data_o <= rom_data;
                busy_o     <= 1'b1;
                done_o     <= 1'b0;
            end
`ifdef BP_CFG_SEQ_READBACK_EN
            // Starting clears the sticky flag; leaving WAIT folds in this read's result.
            if (state_q == e_idle || state_q == e_done) error_q <= 1'b0;
            else if (rdata_i != cfg_data_o)             error_q <= 1'b1;
`endif
        end
`ifdef BP_CFG_SEQ_READBACK_EN
        else begin
            // Read reuses the held core/addr/data of the write just accepted.
            case (state_q)
                e_cfg, e_unfrz: if (cfg_ready_i) begin
                    state_q <= e_rd;
                    cfg_w_o <= 1'b0;
                end
                e_rd: if (cfg_ready_i) begin
                    state_q <= e_wait;
                    cfg_v_o <= 1'b0;
                end
                default: ;
            endcase
        end
`endif
    end

endmodule

// File: tb/tb_bp_cfg_sequencer.sv
// Bench for bp_cfg_sequencer: 2-core and 3-core instances against a transaction-list model.
// Covers the BP_CFG_SEQ_READBACK_EN build when that macro is defined.
module tb_bp_cfg_sequencer;
    import bp_cfg_seq_pkg::*;

`ifdef BP_CFG_SEQ_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    typedef struct packed {
        logic        w;
        logic [7:0]  core;
        logic [15:0] addr;
        logic [63:0] data;
    } tx_t;

    logic        clk, rst_n, start;
    logic        cfg_v [2];
    logic        cfg_w [2];
    logic [7:0]  cfg_core [2];
    logic [15:0] cfg_addr [2];
    logic [63:0] cfg_data [2];
    logic        ready [2];
    logic        rdata_v [2];
    logic [63:0] rdata [2];
    logic        busy [2];
    logic        done [2];
    logic        err [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        bp_cfg_sequencer #(
            .num_core_p       (g + 2),
            .core_id_width_p  (8),
            .cfg_addr_width_p (16),
            .cfg_data_width_p (64),
            .boot_pc_p        (64'h8000_0000),
            .cce_mode_p       (0)
        ) u_dut (
            .clk_i       (clk),
            .reset_n_i   (rst_n),
            .start_i     (start),
            .cfg_v_o     (cfg_v[g]),
            .cfg_ready_i (ready[g]),
            .cfg_w_o     (cfg_w[g]),
            .cfg_core_o  (cfg_core[g]),
            .cfg_addr_o  (cfg_addr[g]),
            .cfg_data_o  (cfg_data[g]),
            .rdata_v_i   (rdata_v[g]),
            .rdata_i     (rdata[g]),
            .busy_o      (busy[g]),
            .done_o      (done[g]),
            .error_o     (err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: expected transaction list plus where each instance stands in it.
    tx_t txl [2][64];
    int  len [2];
    int  idx [2];
    int  m [2];        // 0 idle, 1 running, 2 done
    bit  in_wait [2];
    bit  err_exp [2];
    int  resp_cnt [2];
    int  dut_txn [2];
    int  ready_pct = 100;
    bit  corrupt_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic void add_tx(int g, int c, logic [15:0] a, logic [63:0] d);
        txl[g][len[g]] = '{w: 1'b1, core: 8'(c), addr: a, data: d};
        len[g]++;
        if (RB != 0) begin
            txl[g][len[g]] = '{w: 1'b0, core: 8'(c), addr: a, data: d};
            len[g]++;
        end
    endfunction

    function automatic void build_model();
        for (int g = 0; g < 2; g++) begin
            len[g] = 0;
            for (int c = 0; c < g + 2; c++) begin
                add_tx(g, c, cfg_addr_freeze_lp,   64'd1);
                add_tx(g, c, cfg_addr_core_id_lp,  64'(c));
                add_tx(g, c, cfg_addr_cce_id_lp,   64'(c));
                add_tx(g, c, cfg_addr_cce_mode_lp, 64'd0);
                add_tx(g, c, cfg_addr_npc_lp,      64'h8000_0000);
            end
            for (int c = 0; c < g + 2; c++) add_tx(g, c, cfg_addr_freeze_lp, 64'd0);
        end
    endfunction

    // Model update at the clock edge, compare and drive on the falling edge.
    initial begin
        for (int g = 0; g < 2; g++) begin
            ready[g] = 1'b0; rdata_v[g] = 1'b0; rdata[g] = '0;
            m[g] = 0; idx[g] = 0; in_wait[g] = 1'b0; err_exp[g] = 1'b0;
            resp_cnt[g] = 0; dut_txn[g] = 0;
        end
        forever begin
            @(posedge clk);
            for (int g = 0; g < 2; g++) begin
                if (!rst_n) begin
                    m[g] = 0; in_wait[g] = 1'b0; resp_cnt[g] = 0;
                end else if (m[g] == 1) begin
                    if (in_wait[g]) begin
                        if (rdata_v[g]) begin
                            if (rdata[g] != txl[g][idx[g]-1].data) err_exp[g] = 1'b1;
                            in_wait[g] = 1'b0;
                            if (idx[g] == len[g]) m[g] = 2;
                        end
                    end else if (ready[g]) begin
                        idx[g]++;
                        if (!txl[g][idx[g]-1].w)   in_wait[g] = 1'b1;
                        else if (idx[g] == len[g]) m[g] = 2;
                    end
                end else if (start) begin
                    m[g] = 1; idx[g] = 0; in_wait[g] = 1'b0; err_exp[g] = 1'b0;
                end
            end
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (rst_n) begin
                    chk($sformatf("busy[%0d]", g), busy[g], m[g] == 1);
                    chk($sformatf("done[%0d]", g), done[g], m[g] == 2);
                    chk($sformatf("error[%0d]", g), err[g], err_exp[g]);
                    chk($sformatf("cfg_v[%0d]", g), cfg_v[g], (m[g] == 1) && !in_wait[g]);
                    if (cfg_v[g] && m[g] == 1 && !in_wait[g]) begin
                        chk($sformatf("tx[%0d].%0d", g, idx[g]),
                            {cfg_w[g], cfg_core[g], cfg_addr[g], cfg_data[g]}, txl[g][idx[g]]);
                        chk($sformatf("core_range[%0d]", g), cfg_core[g] < 8'(g + 2), 1'b1);
                    end
                end
                ready[g]   = ($urandom_range(0, 99) < ready_pct);
                rdata_v[g] = 1'b0;
                rdata[g]   = {$urandom, $urandom};
                if (in_wait[g]) begin
                    if (resp_cnt[g] == 0) resp_cnt[g] = $urandom_range(1, 3);
                    resp_cnt[g]--;
                    if (resp_cnt[g] == 0) begin
                        rdata_v[g] = 1'b1;
                        rdata[g]   = txl[g][idx[g]-1].data;
                        if (corrupt_en && txl[g][idx[g]-1].core == 8'd0 &&
                            txl[g][idx[g]-1].addr == cfg_addr_npc_lp)
                            rdata[g] = rdata[g] ^ 64'h10;
                    end
                end else if ($urandom_range(0, 9) == 0) begin
                    rdata_v[g] = 1'b1;  // stray strobe outside WAIT
                end
                if (cfg_v[g] && ready[g]) dut_txn[g]++;
            end
        end
    end

    task automatic pulse_start(input bit clr);
        @(negedge clk);
        #1;
        start = 1'b1;
        if (clr) begin
            dut_txn[0] = 0;
            dut_txn[1] = 0;
        end
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (done[0] && done[1]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_reached", ok, 1'b1);
        chk("txn_count[0]", dut_txn[0], (RB != 0) ? 24 : 12);
        chk("txn_count[1]", dut_txn[1], (RB != 0) ? 36 : 18);
    endtask

    task automatic chk_all_zero(input string tag);
        for (int g = 0; g < 2; g++)
            chk($sformatf("%s[%0d]", tag, g),
                {cfg_v[g], cfg_w[g], cfg_core[g], cfg_addr[g], cfg_data[g], busy[g], done[g], err[g]}, '0);
    endtask

    logic [87:0] lit [12];
    bit          found;

    initial begin
        lit = '{
            {8'd0, 16'h0002, 64'd1}, {8'd0, 16'h0004, 64'd0}, {8'd0, 16'h0005, 64'd0},
            {8'd0, 16'h0006, 64'd0}, {8'd0, 16'h0007, 64'h8000_0000},
            {8'd1, 16'h0002, 64'd1}, {8'd1, 16'h0004, 64'd1}, {8'd1, 16'h0005, 64'd1},
            {8'd1, 16'h0006, 64'd0}, {8'd1, 16'h0007, 64'h8000_0000},
            {8'd0, 16'h0002, 64'd0}, {8'd1, 16'h0002, 64'd0}
        };
        build_model();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_out");
        #1 rst_n = 1'b1;

        // Full-speed run on the 2-core instance against the hand-written table.
        ready_pct = 100;
        pulse_start(1'b1);
`ifndef BP_CFG_SEQ_READBACK_EN
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("lit_tx%0d", i), {cfg_v[0], cfg_w[0], cfg_core[0], cfg_addr[0], cfg_data[0]},
                {2'b11, lit[i]});
            @(negedge clk);
            #1;
        end
        chk("lit_done", {busy[0], done[0]}, 2'b01);
`endif
        wait_done();

        // Restart from DONE under backpressure.
        ready_pct = 30;
        pulse_start(1'b1);
        chk("restart_done_drop", {busy[0], done[0]}, 2'b10);
        wait_done();

        // Second start mid-sequence is ignored.
        ready_pct = 100;
        pulse_start(1'b1);
        repeat (4) @(negedge clk);
        pulse_start(1'b0);
        wait_done();

        // Asynchronous reset while core 1 reg 2 is on the bus.
        ready_pct = 30;
        pulse_start(1'b1);
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (m[0] == 1 && !in_wait[0] && idx[0] == ((RB != 0) ? 14 : 7)) begin
                found = 1'b1;
                break;
            end
        end
        chk("reached_c1_r2", found, 1'b1);
        chk("pre_reset_addr", {cfg_v[0], cfg_w[0], cfg_core[0], cfg_addr[0]}, {2'b11, 8'd1, 16'h0005});
        #1 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        @(negedge clk);
        #1 rst_n = 1'b1;
        pulse_start(1'b1);
        chk("after_reset_first", {cfg_v[0], cfg_w[0], cfg_core[0], cfg_addr[0], cfg_data[0]},
            {2'b11, 8'd0, 16'h0002, 64'd1});
        wait_done();

`ifdef BP_CFG_SEQ_READBACK_EN
        // Corrupted readback of core 0 npc sets a sticky error; sequence still completes.
        ready_pct  = 50;
        corrupt_en = 1'b1;
        pulse_start(1'b1);
        wait_done();
        chk("rb_error[0]", err[0], 1'b1);
        chk("rb_error[1]", err[1], 1'b1);
        corrupt_en = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
